// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// default exception code and the word-alignment function used for bus addresses.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;
  localparam logic [7:0]  BUS_ERR_EXC_DEFAULT    = 8'h05;

  // The backing bus is word-wide; byte selection travels on the write enables.
  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Bundles the memory-stage request, the writeback results and the word-wide
// backing bus that the responder sits between.
interface dmem_responder_if;

  logic        mem_re;
  logic [3:0]  mem_we;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        flush;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic [7:0]  exc_out;
  logic        done_pulse;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  // Responder side.
  modport slave (
    input  mem_re, mem_we, addr, store_data, flush, bus_ack, bus_rdata,
    output stall, load_valid, load_data, exc_out, done_pulse,
           bus_req, bus_we, bus_addr, bus_wdata
  );

  // Pipeline and bus fabric side.
  modport master (
    output mem_re, mem_we, addr, store_data, flush, bus_ack, bus_rdata,
    input  stall, load_valid, load_data, exc_out, done_pulse,
           bus_req, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// Saturating cycle counter for the bus timeout; expired is raised once the
// count reaches LIMIT-1 and stays raised until the next clear.
module dmem_timeout_ctr #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH-1:0] MAX  = '1;

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q >= LAST);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store from the memory stage, runs it
// on the req/ack backing bus, stalls the pipeline meanwhile and reports result.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [7:0]  BUS_ERR_EXC    = BUS_ERR_EXC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  dmem_responder_if.slave  dif
);

  state_e state_q, state_d;

  logic        req_present;
  logic        accept;
  logic        ack_done;
  logic        timeout;
  logic        stall_c;
  logic        expired;

  logic        bus_req_q;
  logic [3:0]  bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic        is_load_q;
  logic        discard_q;
  logic        error_q;
  logic        load_valid_q;
  logic [31:0] load_data_q;
  logic [7:0]  exc_q;
  logic        done_q;

  assign req_present = dif.mem_re || (dif.mem_we != 4'b0000);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    accept   = 1'b0;
    ack_done = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = req_present && !dif.flush;
        if (req_present && !dif.flush) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        // A late ack still beats the timeout in the same cycle.
        if (dif.bus_ack) begin
          ack_done = 1'b1;
          state_d  = DONE;
        end else if (expired) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  dmem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (8)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clk_en && accept),
    .enable  (clk_en && (state_q == BUSY) && !dif.bus_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_q    <= 1'b0;
      bus_we_q     <= 4'b0000;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      is_load_q    <= 1'b0;
      discard_q    <= 1'b0;
      error_q      <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      exc_q        <= '0;
      done_q       <= 1'b0;
    end else if (clk_en) begin
      load_valid_q <= 1'b0;
      exc_q        <= '0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            bus_addr_q  <= word_align(dif.addr);
            bus_we_q    <= dif.mem_we;
            bus_wdata_q <= dif.store_data;
            // A store wins over a simultaneous load.
            is_load_q   <= (dif.mem_we == 4'b0000);
            bus_req_q   <= 1'b1;
            discard_q   <= 1'b0;
            error_q     <= 1'b0;
          end
        end
        BUSY: begin
          // The bus transaction is never aborted; a flush only hides its result.
          if (dif.flush) begin
            discard_q <= 1'b1;
          end
          if (ack_done) begin
            bus_req_q <= 1'b0;
            if (is_load_q) begin
              load_data_q <= dif.bus_rdata;
            end
          end else if (timeout) begin
            bus_req_q   <= 1'b0;
            load_data_q <= '0;
            error_q     <= 1'b1;
          end
        end
        DONE: begin
          load_valid_q <= is_load_q && !discard_q && !error_q;
          exc_q        <= (error_q && !discard_q) ? BUS_ERR_EXC : 8'h00;
          done_q       <= !discard_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign dif.stall      = stall_c;
  assign dif.bus_req    = bus_req_q;
  assign dif.bus_we     = bus_we_q;
  assign dif.bus_addr   = bus_addr_q;
  assign dif.bus_wdata  = bus_wdata_q;
  assign dif.load_valid = load_valid_q;
  assign dif.load_data  = load_data_q;
  assign dif.exc_out    = exc_q;
  assign dif.done_pulse = done_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a default-timeout instance checked through
// a result scoreboard, plus a short-timeout instance for timeout and clk_en cases.
module tb_dmem_responder;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic [7:0]  exc;
    logic        chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  logic clk_en_t = 1'b1;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_responder_if m ();
  dmem_responder_if tm ();

  dmem_responder #(
    .TIMEOUT_CYCLES (16),
    .BUS_ERR_EXC    (8'h05)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .dif    (m)
  );

  dmem_responder #(
    .TIMEOUT_CYCLES (4),
    .BUS_ERR_EXC    (8'h05)
  ) dut_to (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en_t),
    .dif    (tm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result monitor for the default instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (m.done_pulse === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(m.done_pulse), 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_load_valid", 32'(m.load_valid), 32'(e.lv));
          check("sb_exc_out", 32'(m.exc_out), 32'(e.exc));
          if (e.chk_data) check("sb_load_data", m.load_data, e.ld);
        end
      end else begin
        check("quiet_pulses", 32'({m.load_valid, m.exc_out}), 32'd0);
      end
    end
  end

  // Presents one request on the default instance; ack_at / flush_at count BUSY
  // cycles from 1. Returns positioned in the DONE cycle with the request still held.
  task automatic do_req(input logic re, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                        input int flush_at);
    exp_t e;
    logic [31:0] a_word;
    a_word = a;
    a_word[1:0] = 2'b00;
    @(negedge clk);
    m.mem_re = re;
    m.mem_we = we;
    m.addr = a;
    m.store_data = wd;
    m.flush = 1'b0;
    m.bus_ack = 1'b0;
    #1;
    check("stall_request", 32'(m.stall), 32'd1);
    if (flush_at == 0) begin
      e.lv = (we == 4'b0000);
      e.ld = rd;
      e.exc = 8'h00;
      e.chk_data = (we == 4'b0000);
      sb.push_back(e);
    end
    for (int c = 1; c <= ack_at; c++) begin
      @(negedge clk);
      check("bus_req_busy", 32'(m.bus_req), 32'd1);
      check("bus_addr", m.bus_addr, a_word);
      check("bus_we", 32'(m.bus_we), 32'(we));
      check("bus_wdata", m.bus_wdata, wd);
      check("stall_busy", 32'(m.stall), 32'd1);
      m.flush = (c == flush_at);
      m.bus_ack = (c == ack_at);
      m.bus_rdata = (c == ack_at) ? rd : ~rd;
    end
    @(negedge clk);
    m.flush = 1'b0;
    m.bus_ack = 1'b0;
    m.bus_rdata = 32'h0;
    #1;
    check("bus_req_done", 32'(m.bus_req), 32'd0);
    check("stall_done", 32'(m.stall), 32'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    m.mem_re = 1'b0;
    m.mem_we = 4'b0000;
    m.flush = 1'b0;
  endtask

  // Short-timeout instance with bus_ack held low; clk_en_t is dropped at BUSY
  // cycle frz_from for frz_len cycles.
  task automatic do_timeout(input logic [31:0] a, input int frz_from, input int frz_len);
    @(negedge clk);
    tm.mem_re = 1'b1;
    tm.addr = a;
    tm.bus_ack = 1'b0;
    for (int c = 1; c <= 4 + frz_len; c++) begin
      @(negedge clk);
      check("to_bus_req_busy", 32'(tm.bus_req), 32'd1);
      check("to_stall_busy", 32'(tm.stall), 32'd1);
      if (c == frz_from) clk_en_t = 1'b0;
      if (c == frz_from + frz_len) clk_en_t = 1'b1;
    end
    @(negedge clk);
    check("to_bus_req_done", 32'(tm.bus_req), 32'd0);
    check("to_stall_done", 32'(tm.stall), 32'd0);
    @(negedge clk);
    tm.mem_re = 1'b0;
    check("to_done_pulse", 32'(tm.done_pulse), 32'd1);
    check("to_exc_out", 32'(tm.exc_out), 32'h05);
    check("to_load_valid", 32'(tm.load_valid), 32'd0);
    check("to_load_data", tm.load_data, 32'h0);
    @(negedge clk);
    check("to_pulse_clear", 32'({tm.done_pulse, tm.exc_out}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m.mem_re = 1'b0;
    m.mem_we = 4'b0000;
    m.addr = 32'h0;
    m.store_data = 32'h0;
    m.flush = 1'b0;
    m.bus_ack = 1'b0;
    m.bus_rdata = 32'h0;
    tm.mem_re = 1'b0;
    tm.mem_we = 4'b0000;
    tm.addr = 32'h0;
    tm.store_data = 32'h0;
    tm.flush = 1'b0;
    tm.bus_ack = 1'b0;
    tm.bus_rdata = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_bus_req", 32'(m.bus_req), 32'd0);
    check("rst_bus_we", 32'(m.bus_we), 32'd0);
    check("rst_bus_addr", m.bus_addr, 32'h0);
    check("rst_bus_wdata", m.bus_wdata, 32'h0);
    check("rst_load_valid", 32'(m.load_valid), 32'd0);
    check("rst_load_data", m.load_data, 32'h0);
    check("rst_exc_out", 32'(m.exc_out), 32'd0);
    check("rst_done_pulse", 32'(m.done_pulse), 32'd0);
    check("rst_stall", 32'(m.stall), 32'd0);
    check("rst_to_bus_req", 32'(tm.bus_req), 32'd0);
    rst_n = 1'b1;

    // Load acked on the first BUSY cycle, then back-to-back store with 5-cycle ack.
    do_req(1'b1, 4'b0000, 32'h0000_1006, 32'h0, 1, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 4'b0011, 32'h0000_2003, 32'h0000_ABCD, 5, 32'h1111_2222, 0);
    // Load and store together: the store wins.
    do_req(1'b1, 4'b1111, 32'h0000_3000, 32'h5A5A_A5A5, 2, 32'h3333_4444, 0);
    // Flushed load: bus_req held until the ack three cycles later, result hidden.
    do_req(1'b1, 4'b0000, 32'h0000_4000, 32'h0, 4, 32'h7777_8888, 1);
    do_req(1'b1, 4'b0000, 32'h0000_5008, 32'h0, 2, 32'h1234_5678, 0);
    idle_cycle();

    // Request presented together with flush in IDLE is never accepted.
    @(negedge clk);
    m.mem_re = 1'b1;
    m.addr = 32'h0000_6000;
    m.flush = 1'b1;
    #1;
    check("flush_idle_stall", 32'(m.stall), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("flush_idle_bus_req", 32'(m.bus_req), 32'd0);
    end
    m.mem_re = 1'b0;
    m.flush = 1'b0;

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    m.mem_re = 1'b1;
    m.addr = 32'h0000_7000;
    @(negedge clk);
    check("pre_rst_bus_req", 32'(m.bus_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bus_req", 32'(m.bus_req), 32'd0);
    m.mem_re = 1'b0;
    #1;
    check("async_rst_idle_stall", 32'(m.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b1, 4'b0000, 32'h0000_800C, 32'h0, 3, 32'hA5A5_0F0F, 0);
    idle_cycle();
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Short-timeout instance: a normal load first so load_data is non-zero.
    @(negedge clk);
    tm.mem_re = 1'b1;
    tm.addr = 32'h0000_9004;
    @(negedge clk);
    tm.bus_ack = 1'b1;
    tm.bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    tm.bus_ack = 1'b0;
    @(negedge clk);
    tm.mem_re = 1'b0;
    check("to_first_load_valid", 32'(tm.load_valid), 32'd1);
    check("to_first_load_data", tm.load_data, 32'hCAFE_F00D);

    // Timeout after 4 BUSY cycles, then with clk_en low for 3 of them.
    do_timeout(32'h0000_A008, 0, 0);
    do_timeout(32'h0000_B000, 2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
